mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/bus_timeout_cnt.sv | 33 +++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared processor package for the memory arbiter slice.
// Provides the datapath width, byte-enable width and the arbiter FSM state type.
package mem_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_LS = 2'b10
    } arb_state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// BUSY-cycle watchdog for the memory arbiter.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - restart the count (asserted on grant)
//   enable      - count this cycle (asserted while a transaction is outstanding)
//   expired     - high during the TIMEOUT_CYCLES-th counted cycle
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count holds the number of completed BUSY cycles, so the cycle in
    // which it equals TIMEOUT_CYCLES-1 is the last one allowed to see an ack.
    localparam logic [9:0] LIMIT = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 10'd1;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: instruction fetch (if_*) and load/store (ls_*)
// share one memory bus (bus_*). One transaction at a time, with a one-deep
// fairness flag on contested arbitration and a BUSY-cycle timeout.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   if_req_i/if_addr_i          - fetch read request and word address
//   if_gnt_o                    - fetch grant (combinational, IDLE only)
//   if_rvalid_o/if_err_o/if_rdata_o - fetch response pulse, error, data
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_be_i - load/store command
//   ls_gnt_o                    - load/store grant (combinational, IDLE only)
//   ls_rvalid_o/ls_err_o/ls_rdata_o - load/store response pulse, error, data
//   bus_req_o/bus_we_o/bus_addr_o/bus_wdata_o/bus_be_o - registered bus command
//   bus_ack_i/bus_rdata_i       - bus completion and read data
//   stall_o                     - pipeline hold
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DATA_PRIO      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic            if_err_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    input  logic [BE_W-1:0] ls_be_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic            ls_err_o,
    output logic [XLEN-1:0] ls_rdata_o,

    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [BE_W-1:0] bus_be_o,
    input  logic            bus_ack_i,
    input  logic [XLEN-1:0] bus_rdata_i,

    output logic            stall_o
);

    arb_state_e state_q, state_d;

    // Set when the non-preferred port lost the most recent contested
    // arbitration; it then takes the next tie. When the preferred port lost,
    // plain priority already favours it, so one bit is enough.
    logic fair_q;

    logic tie_to_if;
    logic contested;
    logic busy;
    logic expired;
    logic done;
    logic grant;

    assign busy      = (state_q != IDLE);
    assign contested = rst_n && (state_q == IDLE) && if_req_i && ls_req_i;
    assign tie_to_if = DATA_PRIO ? fair_q : ~fair_q;
    assign done      = busy && (bus_ack_i || expired);
    assign grant     = if_gnt_o || ls_gnt_o;

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (grant),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        if_gnt_o = 1'b0;
        ls_gnt_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if (if_req_i && ls_req_i) begin
                        if (tie_to_if) begin
                            if_gnt_o = 1'b1;
                        end else begin
                            ls_gnt_o = 1'b1;
                        end
                    end else if (if_req_i) begin
                        if_gnt_o = 1'b1;
                    end else if (ls_req_i) begin
                        ls_gnt_o = 1'b1;
                    end
                end
                if (if_gnt_o) begin
                    state_d = BUSY_IF;
                end else if (ls_gnt_o) begin
                    state_d = BUSY_LS;
                end
            end
            BUSY_IF, BUSY_LS: begin
                // Ack and expiry together still complete normally; the
                // response path below keys the error flag on ack alone.
                if (bus_ack_i || expired) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fair_q      <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= '0;
            if_rvalid_o <= 1'b0;
            if_err_o    <= 1'b0;
            if_rdata_o  <= '0;
            ls_rvalid_o <= 1'b0;
            ls_err_o    <= 1'b0;
            ls_rdata_o  <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            if_err_o    <= 1'b0;
            ls_rvalid_o <= 1'b0;
            ls_err_o    <= 1'b0;

            if (contested) begin
                fair_q <= DATA_PRIO ? ls_gnt_o : if_gnt_o;
            end

            if (if_gnt_o) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= '0;
                bus_be_o    <= '1;
            end else if (ls_gnt_o) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= ls_we_i;
                bus_addr_o  <= ls_addr_i;
                bus_wdata_o <= ls_wdata_i;
                bus_be_o    <= ls_be_i;
            end else if (done) begin
                bus_req_o   <= 1'b0;
            end

            if (done) begin
                if (state_q == BUSY_IF) begin
                    if_rvalid_o <= 1'b1;
                    if_err_o    <= ~bus_ack_i;
                    if_rdata_o  <= bus_ack_i ? bus_rdata_i : '0;
                end else begin
                    ls_rvalid_o <= 1'b1;
                    ls_err_o    <= ~bus_ack_i;
                    ls_rdata_o  <= (bus_ack_i && !bus_we_o) ? bus_rdata_i : '0;
                end
            end
        end
    end

    assign stall_o = (if_req_i & ~if_gnt_o) | (ls_req_i & ~ls_gnt_o) | busy;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i, ls_we_i;
    logic [31:0] ls_addr_i, ls_wdata_i;
    logic [3:0]  ls_be_i;
    logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [31:0] ls_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;

    mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .DATA_PRIO      (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_err_o    (if_err_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_be_i     (ls_be_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_err_o    (ls_err_o),
        .ls_rdata_o  (ls_rdata_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_be_o    (bus_be_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .stall_o     (stall_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: which port lost the last contested arbitration
    // (-1 none yet, 0 fetch, 1 load/store) and the response owed next cycle.
    int          last_loser = -1;
    int          pend_port  = -1;
    bit          pend_err;
    logic [31:0] pend_rdata;

    bit          r_if, r_ls, r_we, r_idle_ack;
    int          r_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge in the cycle after a completed transaction.
    task automatic check_pending();
        check("if_rvalid", if_rvalid_o, (pend_port == 0));
        check("ls_rvalid", ls_rvalid_o, (pend_port == 1));
        check("bus_req_idle", bus_req_o, 0);
        if (pend_port == 0) begin
            check("if_err", if_err_o, pend_err);
            check("if_rdata", if_rdata_o, pend_rdata);
        end else if (pend_port == 1) begin
            check("ls_err", ls_err_o, pend_err);
            check("ls_rdata", ls_rdata_o, pend_rdata);
        end
        pend_port = -1;
    endtask

    // One arbitration round starting at posedge+1 in IDLE. d = BUSY cycle in
    // which ack arrives (d > TO means no ack, so the timeout fires).
    task automatic txn(input bit ifr, input bit lsr, input bit we,
                       input logic [31:0] ia, input logic [31:0] la,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int d, input logic [31:0] rd, input bit idle_ack);
        int          win;
        logic [31:0] exp_addr;
        win = -1;
        if (ifr && lsr) begin
            if (last_loser == -1) win = 1;   // load/store preferred on ties
            else win = last_loser;
            last_loser = 1 - win;
        end else if (ifr) begin
            win = 0;
        end else if (lsr) begin
            win = 1;
        end
        exp_addr = (win == 0) ? ia : la;

        if_req_i = ifr; if_addr_i = ia;
        ls_req_i = lsr; ls_we_i = we; ls_addr_i = la; ls_wdata_i = wd; ls_be_i = be;
        bus_ack_i = idle_ack; bus_rdata_i = rd;
        @(negedge clk);
        check_pending();
        check("if_gnt", if_gnt_o, (win == 0));
        check("ls_gnt", ls_gnt_o, (win == 1));
        check("stall_arb", stall_o, (ifr && lsr));
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        if (win < 0) return;

        // Scramble the request side: the captured command must not follow it.
        if ($urandom_range(0, 1) == 1) begin
            if_req_i = 1'b0;
            ls_req_i = 1'b0;
        end
        if_addr_i  = $urandom;
        ls_addr_i  = $urandom;
        ls_wdata_i = $urandom;
        ls_be_i    = 4'($urandom);
        ls_we_i    = 1'($urandom);

        for (int k = 1; k <= TO; k++) begin
            bus_ack_i   = (k == d);
            bus_rdata_i = (k == d) ? rd : $urandom;
            @(negedge clk);
            check("bus_req", bus_req_o, 1);
            check("bus_addr", bus_addr_o, exp_addr);
            check("bus_we", bus_we_o, (win == 1) && we);
            if (win == 1) begin
                check("bus_wdata", bus_wdata_o, wd);
                check("bus_be", bus_be_o, be);
            end
            check("stall_busy", stall_o, 1);
            check("rvalid_busy", {if_rvalid_o, ls_rvalid_o}, 0);
            @(posedge clk); #1;
            if (k == d) break;
        end
        bus_ack_i  = 1'b0;
        if_req_i   = 1'b0;
        ls_req_i   = 1'b0;
        pend_port  = win;
        pend_err   = (d > TO);
        pend_rdata = ((d <= TO) && !(win == 1 && we)) ? rd : 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h80;
        ls_wdata_i = 32'hFFFF_FFFF; ls_be_i = 4'hF;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hA5A5_A5A5;

        @(posedge clk); #1;
        @(negedge clk);
        check("rst_if_gnt", if_gnt_o, 0);
        check("rst_ls_gnt", ls_gnt_o, 0);
        check("rst_bus_req", bus_req_o, 0);
        check("rst_bus_addr", bus_addr_o, 0);
        check("rst_bus_wdata", bus_wdata_o, 0);
        check("rst_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
        check("rst_if_rdata", if_rdata_o, 0);
        check("rst_ls_rdata", ls_rdata_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        if_req_i = 1'b0; ls_req_i = 1'b0; bus_ack_i = 1'b0;

        // Single fetch, ack on the 2nd BUSY cycle.
        txn(1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 0);
        // Four back-to-back contested arbitrations: LS, IF, LS, IF.
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0, 32'h1000 + i, 32'h5000 + i, 32'h0, 4'hF, 1, $urandom, 0);
        end
        // Store: fields held until ack, response data zero.
        txn(0, 1, 1, 32'h0, 32'h2000, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_FFFF, 0);
        // Timeout without ack, then ack exactly in the last allowed cycle.
        txn(0, 1, 0, 32'h0, 32'h3000, 32'h0, 4'hF, TO + 5, 32'h1111_1111, 0);
        txn(0, 1, 0, 32'h0, 32'h3004, 32'h0, 4'hF, TO, 32'h2222_2222, 0);
        txn(1, 0, 0, 32'h3008, 32'h0, 32'h0, 4'h0, TO + 1, 32'h3333_3333, 0);
        // Ack while idle must not produce a response.
        txn(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1, 32'h4444_4444, 1);
        txn(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0);

        for (int t = 0; t < 250; t++) begin
            r_if       = 1'($urandom_range(0, 1));
            r_ls       = 1'($urandom_range(0, 1));
            r_we       = 1'($urandom_range(0, 1));
            r_d        = $urandom_range(1, TO + 2);
            r_idle_ack = 1'($urandom_range(0, 1));
            txn(r_if, r_ls, r_we, $urandom, $urandom, $urandom, 4'($urandom),
                r_d, $urandom, r_idle_ack);
        end

        // Leave the fairness flag owing the fetch port, then reset mid-BUSY.
        txn(1, 1, 0, 32'h6000, 32'h6100, 32'h0, 4'hF, 1, $urandom, 0);
        if (last_loser != 0) begin
            txn(1, 1, 0, 32'h6004, 32'h6104, 32'h0, 4'hF, 1, $urandom, 0);
        end
        if_req_i = 1'b0; ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h7000;
        @(negedge clk);
        check_pending();
        check("rb_ls_gnt", ls_gnt_o, 1);
        @(posedge clk); #1;
        ls_req_i = 1'b0;
        @(negedge clk);
        check("rb_bus_req", bus_req_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        check("rb_bus_req_off", bus_req_o, 0);
        check("rb_rvalid0", {if_rvalid_o, ls_rvalid_o}, 0);
        check("rb_idle_stall", stall_o, 0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        check("rb_rvalid1", {if_rvalid_o, ls_rvalid_o}, 0);
        check("rb_ls_rdata", ls_rdata_o, 0);
        @(posedge clk); #1;
        last_loser = -1;
        pend_port  = -1;
        txn(1, 1, 0, 32'h8000, 32'h8100, 32'h0, 4'hF, 2, 32'h5555_AAAA, 0);
        txn(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
